// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with registered read data and fill-level status
// Define FIFO_ERR_FLAGS_EN to build the sticky overflow/underflow flag registers.
module sync_fifo #(
  parameter int DATA_WIDTH    = 8,
  parameter int DEPTH         = 16,
  parameter int PTR_WIDTH     = 4,
  parameter int AFULL_THRESH  = 12,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  w_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  r_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [PTR_WIDTH:0]    count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [PTR_WIDTH:0] ONE       = {{PTR_WIDTH{1'b0}}, 1'b1};
  localparam logic [PTR_WIDTH:0] AF_LEVEL  = AFULL_THRESH[PTR_WIDTH:0];
  localparam logic [PTR_WIDTH:0] AE_LEVEL  = AEMPTY_THRESH[PTR_WIDTH:0];

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_WIDTH:0]    wptr;
  logic [PTR_WIDTH:0]    rptr;
  logic                  wr_ok;
  logic                  rd_ok;

  // The pointer MSB is the lap bit: equal lows with differing laps means full.
  assign empty        = (wptr == rptr);
  assign full         = (wptr[PTR_WIDTH] != rptr[PTR_WIDTH]) &&
                        (wptr[PTR_WIDTH-1:0] == rptr[PTR_WIDTH-1:0]);
  assign almost_full  = (count >= AF_LEVEL);
  assign almost_empty = (count <= AE_LEVEL);

  assign wr_ok = w_en && !full;
  assign rd_ok = r_en && !empty;

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (!rst && wr_ok) begin
      mem[wptr[PTR_WIDTH-1:0]] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      data_out <= '0;
    end else begin
      if (wr_ok) begin
        wptr <= wptr + ONE;
      end
      if (rd_ok) begin
        rptr     <= rptr + ONE;
        data_out <= mem[rptr[PTR_WIDTH-1:0]];
      end
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: count <= count;
      endcase
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (w_en && full) begin
        overflow <= 1'b1;
      end
      if (r_en && empty) begin
        underflow <= 1'b1;
      end
    end
  end
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// tb/tb_sync_fifo.sv - directed self-checking bench for sync_fifo
module tb_sync_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       w_en;
  logic [7:0] data_in;
  logic       r_en;
  logic [7:0] data_out;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [4:0] count;
  logic       overflow;
  logic       underflow;

  int tests = 0;
  int fails = 0;

`ifdef FIFO_ERR_FLAGS_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  sync_fifo dut (
    .clk          (clk),
    .rst          (rst),
    .w_en         (w_en),
    .data_in      (data_in),
    .r_en         (r_en),
    .data_out     (data_out),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; w_en = 1'b0; r_en = 1'b0; data_in = 8'h00;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_aempty", {31'd0, almost_empty}, 32'd1);
    chk("rst_afull", {31'd0, almost_full}, 32'd0);
    chk("rst_count", {27'd0, count}, 32'd0);
    chk("rst_dout", {24'd0, data_out}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    chk("rst_udf", {31'd0, underflow}, 32'd0);

    // fill 0x01..0x10, watching threshold edges as the count climbs
    w_en = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      data_in = 8'(i);
      tick();
      chk("fill_count", {27'd0, count}, 32'(i));
      chk("fill_afull", {31'd0, almost_full}, (i >= 12) ? 32'd1 : 32'd0);
      chk("fill_aempty", {31'd0, almost_empty}, (i <= 4) ? 32'd1 : 32'd0);
      chk("fill_full", {31'd0, full}, (i == 16) ? 32'd1 : 32'd0);
    end
    data_in = 8'hFF;
    tick();
    chk("ovf_count", {27'd0, count}, 32'd16);
    chk("ovf_full", {31'd0, full}, 32'd1);
    chk("ovf_flag", {31'd0, overflow}, {31'd0, ERR_EN});

    // drain in order
    w_en = 1'b0; r_en = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk("drain_data", {24'd0, data_out}, 32'(i));
      chk("drain_count", {27'd0, count}, 32'(16 - i));
      chk("drain_aempty", {31'd0, almost_empty}, ((16 - i) <= 4) ? 32'd1 : 32'd0);
    end
    chk("drain_empty", {31'd0, empty}, 32'd1);
    tick();
    chk("udf_dout", {24'd0, data_out}, 32'h10);
    chk("udf_count", {27'd0, count}, 32'd0);
    chk("udf_flag", {31'd0, underflow}, {31'd0, ERR_EN});
    r_en = 1'b0;

    // wrap-around: pointers start at index 0 of lap 1, second pass crosses 15->0
    for (int pass = 0; pass < 2; pass++) begin
      w_en = 1'b1;
      for (int i = 0; i < 10; i++) begin
        data_in = 8'(8'h20 + pass * 8'h20 + i);
        tick();
      end
      w_en = 1'b0;
      chk("wrap_fill_count", {27'd0, count}, 32'd10);
      r_en = 1'b1;
      for (int i = 0; i < 10; i++) begin
        tick();
        chk("wrap_data", {24'd0, data_out}, 32'(8'h20 + pass * 8'h20 + i));
      end
      r_en = 1'b0;
      chk("wrap_end_count", {27'd0, count}, 32'd0);
    end

    // steady state at count=8 with simultaneous read/write
    w_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      data_in = 8'(8'h60 + i);
      tick();
    end
    r_en = 1'b1;
    for (int k = 0; k < 20; k++) begin
      data_in = 8'(8'h68 + k);
      tick();
      chk("both_data", {24'd0, data_out}, 32'(8'h60 + k));
      chk("both_count", {27'd0, count}, 32'd8);
    end
    w_en = 1'b0;
    for (int k = 20; k < 28; k++) begin
      tick();
      chk("both_drain", {24'd0, data_out}, 32'(8'h60 + k));
    end
    chk("both_end_empty", {31'd0, empty}, 32'd1);

    // simultaneous on empty: write only, no bypass
    w_en = 1'b1; r_en = 1'b1; data_in = 8'hA5;
    tick();
    chk("empty_both_count", {27'd0, count}, 32'd1);
    chk("empty_both_dout", {24'd0, data_out}, 32'h7B);
    w_en = 1'b0;
    tick();
    chk("empty_both_rd", {24'd0, data_out}, 32'hA5);
    r_en = 1'b0;

    // simultaneous on full: read only, write dropped
    w_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      data_in = 8'(8'hB0 + i);
      tick();
    end
    chk("full_pre", {31'd0, full}, 32'd1);
    r_en = 1'b1; data_in = 8'hEE;
    tick();
    chk("full_both_count", {27'd0, count}, 32'd15);
    chk("full_both_dout", {24'd0, data_out}, 32'hB0);
    chk("full_both_full", {31'd0, full}, 32'd0);
    w_en = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("to7_data", {24'd0, data_out}, 32'(8'hB0 + i));
    end
    chk("to7_count", {27'd0, count}, 32'd7);

    // reset mid-stream beats w_en/r_en
    rst = 1'b1; w_en = 1'b1; r_en = 1'b1; data_in = 8'h55;
    tick();
    chk("mrst_count", {27'd0, count}, 32'd0);
    chk("mrst_empty", {31'd0, empty}, 32'd1);
    chk("mrst_dout", {24'd0, data_out}, 32'd0);
    chk("mrst_ovf", {31'd0, overflow}, 32'd0);
    chk("mrst_udf", {31'd0, underflow}, 32'd0);
    rst = 1'b0; w_en = 1'b0; r_en = 1'b0;
    tick();
    chk("post_rst_count", {27'd0, count}, 32'd0);
    chk("post_rst_aempty", {31'd0, almost_empty}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
